fetch_stage_pf: RTL and testbench
=================================

Name: fetch_stage_pf

Overview:
- Parametrised instruction-fetch stage with an in-order, decoupled instruction-memory request/response interface.
- Contains a prefetch FIFO and a valid/ready handshake toward decode.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.
- Sits between the PC-redirect source (execute) and the decode stage, replacing the fixed single-register fetch/decode boundary.

Parameters:
- XLEN, 32: width of PC, addresses and instruction word.
- DEPTH, 4: prefetch FIFO entries; power of two, >=2. Also the bound on (outstanding requests + FIFO occupancy).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses in order, latency >=1, no backpressure
- imem_rsp_data  in  XLEN  instruction word
- dec_valid  out  1  FIFO head valid toward decode
- dec_ready  in  1  decode accepts head
- dec_instr  out  XLEN  head instruction
- dec_pc  out  XLEN  head PC
- dec_pc_plus4  out  XLEN  dec_pc + 4, modulo 2^XLEN

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - fetch_pc = rsp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0; dec_valid = 0; dec_instr/dec_pc/dec_pc_plus4 = 0.
- Request issue: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < DEPTH).
  - imem_req_addr = fetch_pc.
  - Fire = valid && ready. On fire, fetch_pc += 4 (wraps) and outstanding += 1.
  - imem_req_valid and imem_req_addr are held stable while ready is low.
- Response: every imem_rsp_valid decrements outstanding. Fire and response in the same cycle leave the count net unchanged.
  - If drop_cnt > 0: discard the response; drop_cnt -= 1.
  - Else: push {imem_rsp_data, rsp_pc} into the FIFO; rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Decode handshake: dec_* driven combinationally from the FIFO head.
  - Pop when dec_valid && dec_ready.
  - Head contents are stable while dec_valid && !dec_ready.
  - Empty FIFO gives dec_valid = 0. A response written this cycle appears at dec_valid next cycle (latency 1 from rsp to decode).
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (highest priority), on the same edge:
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO flushed; a pop in this cycle is ignored, and the decode handshake is not counted.
  - No request is issued in this cycle.
  - drop_cnt = outstanding - imem_rsp_valid, i.e. all still-in-flight responses. A response arriving in the redirect cycle is discarded.
  - dec_valid = 0 the next cycle.
  - Back-to-back redirects: each recomputes drop_cnt from the current outstanding.
- First request after a redirect is issued the cycle after. First valid instruction reaches decode no earlier than 2 cycles after the request fires with latency 1.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory responses after reset deassertion are the environment's responsibility; the memory is reset on the same rst.
- Invariants:
  - drop_cnt <= outstanding.
  - outstanding + fifo_count <= DEPTH.
  - Counter widths: clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32-bit, +1 per decode pop) and perf_dropped (32-bit, +1 per discarded response plus +1 per flushed FIFO entry).
  - Both counters wrap, reset to 0, and count nothing during rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (fetch_pkg):
  - NOP_INSTR = 32'h00000033.
  - PC_STEP = 4.
  - A packed fetch-entry typedef {instr, pc}, sized by XLEN.
- Sub-module: fetch_fifo. Synchronous FIFO with push/pop/flush, count, full/empty, and pointer wrap via an extra MSB.

Test Plan:
- Reset with RESET_PC=0x100, imem ready=1, latency 1, dec_ready=1 -> requests 0x100, 0x104, 0x108... each cycle; decode sees pc=0x100/instr=mem[0x100] 2 cycles after the first fire, pc_plus4=0x104.
- dec_ready=0 with DEPTH=4 and latency 1 -> at most 4 requests issued, then imem_req_valid=0; FIFO full, head stable at pc=RESET_PC; dec_ready=1 resumes one request per pop.
- Memory latency 3 with 2 outstanding, redirect_pc=0x2002 -> next request addr 0x2000; both stale responses discarded (drop_cnt 2->0); first decoded pc=0x2000.
- Redirect in the same cycle as rsp_valid and dec_valid&&dec_ready -> response discarded, pop not applied, dec_valid=0 next cycle, drop_cnt = outstanding-1.
- imem_req_ready held low 5 cycles -> imem_req_addr stable, fetch_pc unchanged; fetch_pc at 0xFFFFFFFC increments to 0x00000000 (wrap).
- Assert rst mid-stream with FIFO holding 3 entries -> dec_valid=0 and imem_req_valid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC; with FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, fetch-entry type and counter sizing helper for the fetch stage.
package fetch_pkg;
    localparam int FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is combinational, push/pop in the same cycle allowed when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/fetch_stage_pf.sv
// Decoupled fetch stage: credit-limited imem requests, prefetch FIFO to decode, redirect flush/drop; rsp->decode latency 1.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_stage_pf
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;
    entry_t          push_entry;
    entry_t          head;

    assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Every in-flight request owns a FIFO slot, so responses can never overflow it.
    assign credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    assign push       = imem_rsp_valid && !rsp_drop;
    assign pop        = dec_valid && dec_ready && !redirect_valid;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign dec_valid    = !fifo_empty;
    assign dec_instr    = dec_valid ? head.instr : '0;
    assign dec_pc       = dec_valid ? head.pc : '0;
    assign dec_pc_plus4 = dec_valid ? head.pc + XLEN'(PC_STEP) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (fire)     fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
                if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            perf_dropped <= perf_dropped + 32'(rsp_drop)
                          + (redirect_valid ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));
    assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
    assert property (@(posedge clk) disable iff (rst) credits_used <= DEPTH_LIM);
endmodule

// File: tb/tb_fetch_stage_pf.sv
// Directed bench for fetch_stage_pf: in-order memory model, expected decode stream queued per phase, monitor pops and compares.
module tb_fetch_stage_pf;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_stage_pf #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    int           n_chk = 0;
    int           n_pass = 0;
    int           pops = 0;
    int           mem_lat = 1;
    int           cyc = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    logic [31:0]  mq_addr[$];
    int           mq_due[$];
    logic         acc_fire = 1'b0;
    logic [31:0]  acc_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return NOP_INSTR ^ (a << 4) ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic load_exp(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            fetch_entry_t e;
            e.pc    = base + 32'(PC_STEP * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_exp(RST_PC);
    endtask

    // Memory: accepts one request per cycle, answers in order after mem_lat cycles.
    always @(negedge clk) begin
        acc_fire = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (acc_fire) begin
            mq_addr.push_back(acc_addr);
            mq_due.push_back(cyc + mem_lat - 1);
        end
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Decode monitor: every accepted handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready && !redirect_valid) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL dec_unexpected: got pc %h, expected no entry", dec_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("dec_pc", dec_pc, mon_e.pc);
                check("dec_instr", dec_instr, mon_e.instr);
                check("dec_pc_plus4", dec_pc_plus4, mon_e.pc + 32'd4);
            end
        end
    end

    initial begin
        int fires;
        int p0;

        // Reset state and streaming start.
        step();
        smp();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_pc_plus4", dec_pc_plus4, 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        step();
        rst = 1'b0;
        load_exp(RST_PC);
        smp();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h100);
        step();
        smp();
        check("second_req_addr", imem_req_addr, 32'h104);
        check("dec_valid_early", 32'(dec_valid), 32'd0);
        step();
        smp();
        check("first_dec_valid", 32'(dec_valid), 32'd1);
        check("first_dec_pc", dec_pc, 32'h100);
        repeat (8) step();

        // Decode backpressure from reset.
        dec_ready = 1'b0;
        do_reset();
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        check("bp_fires", 32'(fires), 32'd4);
        smp();
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_dec_valid", 32'(dec_valid), 32'd1);
        check("bp_head_pc", dec_pc, RST_PC);
        step();
        dec_ready = 1'b1;
        smp();
        check("bp_no_credit", 32'(imem_req_valid), 32'd0);
        step();
        smp();
        check("bp_resume_valid", 32'(imem_req_valid), 32'd1);
        check("bp_resume_addr", imem_req_addr, 32'h110);
        repeat (8) step();

        // Redirect with two requests in flight at latency 3.
        mem_lat = 3;
        do_reset();
        smp();
        check("lat3_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        smp();
        check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        load_exp(32'h2000);
        p0 = pops;
        smp();
        check("redir_req_addr", imem_req_addr, 32'h2000);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        repeat (12) step();
        check("redir_decoded", 32'(pops > p0), 32'd1);

        // Redirect coinciding with a response and a decode handshake.
        mem_lat = 1;
        do_reset();
        repeat (8) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        smp();
        check("same_dec_valid", 32'(dec_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        load_exp(32'h3000);
        p0 = pops;
        smp();
        check("same_dec_flushed", 32'(dec_valid), 32'd0);
        check("same_req_addr", imem_req_addr, 32'h3000);
        repeat (8) step();
        check("same_decoded", 32'(pops > p0), 32'd1);

        // Request stall and address wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        load_exp(32'hFFFF_FFF8);
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_req_addr", imem_req_addr, 32'hFFFF_FFF8);
            step();
        end
        imem_req_ready = 1'b1;
        smp();
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        step();
        smp();
        check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
        step();
        smp();
        check("wrap_addr2", imem_req_addr, 32'h0000_0000);
        repeat (6) step();
        check("wrap_decoded", 32'(pops > p0), 32'd1);

        // Asynchronous reset with a populated FIFO.
        dec_ready = 1'b0;
        repeat (3) step();
        smp();
        check("pre_rst_dec_valid", 32'(dec_valid), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check("async_dec_valid", 32'(dec_valid), 32'd0);
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_dec_pc", dec_pc, 32'd0);
`ifdef FETCH_PERF_EN
        check("async_perf_fetched", perf_fetched, 32'd0);
        check("async_perf_dropped", perf_dropped, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_exp(RST_PC);
        dec_ready = 1'b1;
        p0 = pops;
        smp();
        check("restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("restart_req_addr", imem_req_addr, RST_PC);
        repeat (8) step();
        check("restart_decoded", 32'(pops > p0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
